// File: rtl/bus_datapath_seq.sv
// Single-bus datapath with register file, Y/Z/HI/LO, ALU and a built-in T-state sequencer.
// Commands run as a series of bus transfers; MUL is an iterative shift-add over WIDTH cycles.
module bus_datapath_seq #(
    parameter  int WIDTH = 32,
    parameter  int NREGS = 16,
    localparam int SW    = $clog2(WIDTH),
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [AW-1:0]    cmd_ra,
    input  logic [AW-1:0]    cmd_rb,
    input  logic [AW-1:0]    cmd_rc,
    input  logic             ext_we,
    input  logic [AW-1:0]    ext_addr,
    input  logic [WIDTH-1:0] ext_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             done,
    output logic             err,
    output logic             busy
);
    localparam int CW = SW + 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SHL  = 4'd4;
    localparam logic [3:0] OP_SHR  = 4'd5;
    localparam logic [3:0] OP_SHRA = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_NEG  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_MFHI = 4'd10;
    localparam logic [3:0] OP_MFLO = 4'd11;

    typedef enum logic [3:0] {
        S_IDLE, S_TY, S_TALU, S_TZ, S_TWB, S_TMINIT, S_TMUL, S_TWBLO, S_TWBHI, S_TERR
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     rf_q [NREGS];
    logic [WIDTH-1:0]     y_q, y_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0]   z_q, z_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           op_q, op_d;
    logic [AW-1:0]        ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
    logic                 done_q, done_d, err_q, err_d;
    logic [WIDTH-1:0]     bus;
    logic                 rf_we;
    logic [AW-1:0]        rf_waddr;
    logic [WIDTH-1:0]     rf_wdata;
    logic [WIDTH:0]       mac_sum;

    function automatic logic [WIDTH-1:0] alu(input logic [3:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] as;
        logic [SW-1:0]           sh;
        as = a;
        sh = b[SW-1:0];
        case (op)
            OP_ADD:  alu = a + b;
            OP_SUB:  alu = a - b;
            OP_AND:  alu = a & b;
            OP_OR:   alu = a | b;
            OP_SHL:  alu = a << sh;
            OP_SHR:  alu = a >> sh;
            OP_SHRA: alu = as >>> sh;
            OP_NOT:  alu = ~a;
            OP_NEG:  alu = -a;
            default: alu = '0;
        endcase
    endfunction

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = ~cmd_ready;
    assign done      = done_q;
    assign err       = err_q;
    assign rd_data   = rf_q[rd_addr];
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;

    // Exactly one bus source per T-state.
    always_comb begin
        bus = '0;
        case (state_q)
            S_TY:              bus = rf_q[rb_q];
            S_TALU, S_TMINIT:  bus = rf_q[rc_q];
            S_TZ:              bus = (op_q == OP_MFHI) ? hi_q : lo_q;
            S_TWB, S_TWBLO:    bus = z_q[WIDTH-1:0];
            S_TWBHI:           bus = z_q[2*WIDTH-1:WIDTH];
            default:           bus = '0;
        endcase
    end

    // Carry out of the partial-product add becomes the new MSB after the shift.
    assign mac_sum = {1'b0, z_q[2*WIDTH-1:WIDTH]} + (z_q[0] ? {1'b0, y_q} : '0);

    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        z_d      = z_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        rc_d     = rc_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = ext_addr;
        rf_wdata = ext_data;
        case (state_q)
            S_IDLE: begin
                rf_we = ext_we;
                if (cmd_valid) begin
                    op_d = cmd_op;
                    ra_d = cmd_ra;
                    rb_d = cmd_rb;
                    rc_d = cmd_rc;
                    if (cmd_op == OP_MFHI || cmd_op == OP_MFLO) state_d = S_TZ;
                    else if (cmd_op > OP_MFLO)                  state_d = S_TERR;
                    else                                        state_d = S_TY;
                end
            end
            S_TY: begin
                y_d     = bus;
                state_d = (op_q == OP_MUL) ? S_TMINIT : S_TALU;
            end
            S_TALU: begin
                z_d     = {{WIDTH{1'b0}}, alu(op_q, y_q, bus)};
                state_d = S_TWB;
            end
            S_TZ: begin
                z_d     = {{WIDTH{1'b0}}, bus};
                state_d = S_TWB;
            end
            S_TWB: begin
                rf_we    = 1'b1;
                rf_waddr = ra_q;
                rf_wdata = bus;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            S_TMINIT: begin
                z_d     = {{WIDTH{1'b0}}, bus};
                cnt_d   = CW'(WIDTH);
                state_d = S_TMUL;
            end
            S_TMUL: begin
                z_d   = {mac_sum, z_q[WIDTH-1:1]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = S_TWBLO;
            end
            S_TWBLO: begin
                lo_d    = bus;
                state_d = S_TWBHI;
            end
            S_TWBHI: begin
                hi_d    = bus;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_TERR: begin
                done_d  = 1'b1;
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            y_q     <= '0;
            z_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            z_q     <= z_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (rf_we) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

endmodule

// File: doc/bus_datapath_seq.md
# bus_datapath_seq

Parametrised successor to the single-bus CPU datapath. It bundles a register file, Y/Z/HI/LO registers and an ALU on one internal bus with a built-in T-state sequencer. Each three-register command is executed as a series of bus transfers, so the control unit only has to issue commands instead of per-cycle strobes. It sits between the instruction decoder (command side) and the register/ALU resources, and adds an iterative shift-add multiplier.

## Interface
- WIDTH, 32: datapath width; power of two, 8..64. SW = clog2(WIDTH) (localparam).
- NREGS, 16: general registers; power of two, 2..64. AW = clog2(NREGS) (localparam).
- clk  in  1  clock; all state changes on its rising edge.
- clr  in  1  reset; asynchronous and active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE; a command is accepted on an edge where cmd_valid && cmd_ready.
- cmd_op  in  4  opcode (see Operation).
- cmd_ra / cmd_rb / cmd_rc  in  AW each  destination / source A / source B register indices.
- ext_we  in  1  external register write; honoured only when cmd_ready=1.
- ext_addr  in  AW  external write index.
- ext_data  in  WIDTH  external write data.
- rd_addr  in  AW  debug read index.
- rd_data  out  WIDTH  combinational R[rd_addr].
- hi_out / lo_out  out  WIDTH  HI and LO register contents.
- done  out  1  one-cycle pulse when a command retires.
- err  out  1  one-cycle pulse together with done for an illegal opcode.
- busy  out  1  equals !cmd_ready.

## Operation
- Opcodes:
  - 0 ADD: ra = rb + rc.
  - 1 SUB: ra = rb - rc.
  - 2 AND.
  - 3 OR.
  - 4 SHL: ra = rb << rc[SW-1:0].
  - 5 SHR: logical.
  - 6 SHRA: arithmetic.
  - 7 NOT: ra = ~rb.
  - 8 NEG: ra = -rb.
  - 9 MUL: {HI,LO} = rb * rc, unsigned, 2*WIDTH-bit.
  - 10 MFHI: ra = HI.
  - 11 MFLO: ra = LO.
  - 12-15: illegal.
- Arithmetic is modulo 2^WIDTH. No flags. Shift amount uses only the low SW bits of rc.
- Datapath: Y is WIDTH bits and Z is 2*WIDTH bits. Every operand transfer drives the internal bus from exactly one source.
- Sources and destinations are captured in Y/Z before writeback, so ra == rb == rc is legal and uses the old values.
- States and transitions:
  - IDLE: on accept, latch op/ra/rb/rc. Go to T_Y; MFHI/MFLO go to T_Z; illegal goes to T_ERR.
  - T_Y: bus = R[rb], Y <= bus. Go to T_ALU; MUL goes to T_MINIT.
  - T_ALU: bus = R[rc], Z <= {0, alu(Y, bus)}. Go to T_WB.
  - T_Z: bus = HI or LO, Z <= {0, bus}. Go to T_WB.
  - T_WB: bus = Zlow, R[ra] <= bus. done=1 next cycle. Go to IDLE.
  - T_MINIT: Z <= {0, R[rc]}, counter <= WIDTH. Go to T_MUL.
  - T_MUL: one shift-add step per cycle (if Z[0], Zhi += Y; then shift Z right 1 with the carry into the MSB). Decrement the counter; at 0 go to T_WBLO.
  - T_WBLO: LO <= Zlow. Go to T_WBHI.
  - T_WBHI: HI <= Zhi. Signal done. Go to IDLE.
  - T_ERR: no register changes; done=1 and err=1. Go to IDLE.
- External write port:
  - ext_we while busy is ignored (dropped, not queued).
  - ext_we on the same edge as a command accept is performed, and that command's T_Y/T_ALU reads see the new value.
- cmd_* inputs are sampled only on the accept edge. Later changes while busy have no effect.

## Timing
- Count edges from the accept edge E0.
- ALU ops: Y at E1, Z at E2, R[ra] at E3. done/err are registered and high during the cycle after E3. cmd_ready is high in that same cycle, so the next accept is possible at E4.
- MFHI/MFLO: Z at E1, R[ra] at E2, done after E2.
- MUL: Y at E1, init at E2, steps at E3..E(2+WIDTH), LO at E(3+WIDTH), HI at E(4+WIDTH), done after that. For WIDTH=32 HI lands at E36.
- Illegal: done/err high during the cycle after E1. No register changes.
- Reset (clr=0, asynchronous, any state including mid-MUL) clears:
  - all R[i], Y, Z, HI, LO to 0;
  - state to IDLE;
  - done, err, busy to 0; cmd_ready to 1.
- Reset release: first accept is possible on the first edge with clr=1.
- rd_data, hi_out and lo_out reflect register state combinationally; writes are visible after the writing edge.

## Test plan
- Reset then ADD: ext-write R1=5, R2=7, ADD ra=3 rb=1 rc=2. Expect R3=12 at E3, a single done pulse, cmd_ready high after E3.
- Wrap and shifts: R1=0 SUB R2=1 gives 0xFFFFFFFF. R4=0x80000000 SHRA by rc=33 gives 0xC0000000 (shift 1). SHR by 4 gives 0x08000000.
- MUL: R1=R2=0xFFFFFFFF, MUL. Expect LO=0x00000001 at E35, HI=0xFFFFFFFE at E36. Then MFHI ra=5 gives R5=0xFFFFFFFE at E2.
- Aliasing and port collisions: ADD ra=rb=rc=1 with R1=3 gives 6. ext_we to R1 while busy is dropped. ext_we coincident with accept is used as the operand.
- Illegal op 13: done+err pulse after E1. All registers, HI and LO unchanged.
- Reset mid-MUL (clr low at E10): all registers 0, cmd_ready=1 immediately, no done. A new ADD after release completes normally.
